// File: rtl/avr_uart_tx_responder.sv
// AVR data-bus UART transmitter: 4-byte register window, TX FIFO, 8N1 serialiser.
// Ports: clock/reset, address/o_data/we (core bus), i_data/sel (registered read), tx; irq with UART_TX_IRQ_EN.
module avr_uart_tx_responder #(
  parameter logic [15:0] BASE       = 16'h0040,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [15:0] BAUD_RESET = 16'd216
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] address,
  input  logic [7:0]  o_data,
  input  logic        we,
  output logic [7:0]  i_data,
  output logic        sel,
  output logic        tx
`ifdef UART_TX_IRQ_EN
  ,
  output logic        irq
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PTR_MSB = {1'b1, {AW{1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE, S_START, S_DATA, S_STOP
  } state_t;

  state_t      state, state_n;
  logic [15:0] div;
  logic [15:0] cnt, cnt_n;
  logic [2:0]  idx, idx_n;
  logic [7:0]  sh, sh_n;
  logic        tx_n;
  logic        pop;

  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        empty, full, push, drop;

  logic        ovf, ie, busy;
  logic [15:0] off;
  logic        in_win;
  logic        wr_dat, wr_sta, wr_blo, wr_bhi, rd_sta;
  logic [7:0]  rd_val;

  assign off    = address - BASE;
  assign in_win = (off[15:2] == 14'd0);
  assign wr_dat = we & in_win & (off[1:0] == 2'd0);
  assign wr_sta = we & in_win & (off[1:0] == 2'd1);
  assign wr_blo = we & in_win & (off[1:0] == 2'd2);
  assign wr_bhi = we & in_win & (off[1:0] == 2'd3);
  assign rd_sta = ~we & in_win & (off[1:0] == 2'd1);

  assign empty = (wr_ptr == rd_ptr);
  assign full  = ((wr_ptr ^ rd_ptr) == PTR_MSB);
  // A pop on the same edge frees a slot, so a full FIFO still accepts.
  assign push  = wr_dat & (~full | pop);
  assign drop  = wr_dat & full & ~pop;
  assign busy  = (state != S_IDLE);

  always_comb begin
    rd_val = 8'h00;
    unique case (off[1:0])
      2'd1:    rd_val = {3'b000, ie, ovf, empty, full, busy};
      2'd2:    rd_val = div[7:0];
      2'd3:    rd_val = div[15:8];
      default: rd_val = 8'h00;
    endcase
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    sh_n    = sh;
    pop     = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          sh_n    = mem[rd_ptr[AW-1:0]];
          cnt_n   = div;
          state_n = S_START;
        end
      end
      S_START: begin
        if (cnt == 16'd0) begin
          cnt_n   = div;
          idx_n   = 3'd0;
          state_n = S_DATA;
        end else begin
          cnt_n = cnt - 16'd1;
        end
      end
      S_DATA: begin
        if (cnt == 16'd0) begin
          cnt_n = div;
          sh_n  = {1'b1, sh[7:1]};
          idx_n = idx + 3'd1;
          if (idx == 3'd7) state_n = S_STOP;
        end else begin
          cnt_n = cnt - 16'd1;
        end
      end
      S_STOP: begin
        if (cnt == 16'd0) state_n = S_IDLE;
        else cnt_n = cnt - 16'd1;
      end
      default: state_n = S_IDLE;
    endcase
    // tx is registered from the next state so it never glitches.
    tx_n = 1'b1;
    if (state_n == S_START) tx_n = 1'b0;
    else if (state_n == S_DATA) tx_n = sh_n[0];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= S_IDLE;
      cnt    <= 16'd0;
      idx    <= 3'd0;
      sh     <= 8'h00;
      tx     <= 1'b1;
      wr_ptr <= '0;
      rd_ptr <= '0;
      div    <= BAUD_RESET;
      ovf    <= 1'b0;
      i_data <= 8'h00;
      sel    <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      idx    <= idx_n;
      sh     <= sh_n;
      tx     <= tx_n;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (wr_blo) div[7:0]  <= o_data;
      if (wr_bhi) div[15:8] <= o_data;
      if (drop) ovf <= 1'b1;
      else if (rd_sta) ovf <= 1'b0;
      i_data <= in_win ? rd_val : 8'h00;
      sel    <= in_win;
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr[AW-1:0]] <= o_data;
  end

`ifdef UART_TX_IRQ_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ie  <= 1'b0;
      irq <= 1'b0;
    end else begin
      if (wr_sta) ie <= o_data[4];
      irq <= ie & empty & ~busy;
    end
  end
`else
  logic unused_sta;
  assign ie         = 1'b0;
  assign unused_sta = wr_sta;
`endif

endmodule

// File: tb/tb_avr_uart_tx_responder.sv
// Bench for avr_uart_tx_responder: scoreboard of sent bytes vs a cycle-exact tx frame monitor.
// Also covers register reads, overflow, mid-frame divisor change and mid-frame reset.
module tb_avr_uart_tx_responder;

  localparam logic [15:0] BASE = 16'h0040;
  localparam logic [15:0] IDLE_A = 16'h0100;

  logic        clock;
  logic        reset;
  logic [15:0] address;
  logic [7:0]  o_data;
  logic        we;
  logic [7:0]  i_data;
  logic        sel;
  logic        tx;
`ifdef UART_TX_IRQ_EN
  logic        irq;
`endif

  avr_uart_tx_responder dut (
    .clock   (clock),
    .reset   (reset),
    .address (address),
    .o_data  (o_data),
    .we      (we),
    .i_data  (i_data),
    .sel     (sel),
    .tx      (tx)
`ifdef UART_TX_IRQ_EN
    ,
    .irq     (irq)
`endif
  );

  int n_chk = 0;
  int n_fail = 0;
  logic [7:0] sb[$];
  bit mon_en = 0;
  bit frame_busy = 0;
  int mon_div = 3;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
    @(negedge clock);
    address = a;
    o_data  = d;
    we      = 1'b1;
    @(negedge clock);
    we      = 1'b0;
    address = IDLE_A;
  endtask

  task automatic bus_read(input logic [15:0] a, output logic [7:0] d,
                          output logic s);
    @(negedge clock);
    address = a;
    we      = 1'b0;
    @(negedge clock);
    d = i_data;
    s = sel;
    address = IDLE_A;
  endtask

  task automatic send(input logic [7:0] d);
    sb.push_back(d);
    bus_write(BASE, d);
  endtask

  task automatic wait_drain(input int lim);
    int k;
    k = 0;
    while ((sb.size() != 0 || frame_busy) && k < lim) begin
      @(negedge clock);
      k++;
    end
    check("drain", 32'(k < lim), 32'd1);
  endtask

  // Frame monitor: checks every cycle of the frame against the expected byte.
  initial begin
    forever begin
      @(negedge clock);
      if (mon_en && tx === 1'b0) begin
        int l, b, bad;
        logic [7:0] e, got;
        logic lvl;
        frame_busy = 1;
        if (sb.size() == 0) begin
          check("spurious frame", 32'd1, 32'd0);
          e = 8'h00;
        end else begin
          e = sb.pop_front();
        end
        l = mon_div + 1;
        bad = 0;
        got = 8'h00;
        for (int c = 0; c < 10 * l; c++) begin
          if (c != 0) @(negedge clock);
          b = c / l;
          if (b == 0) lvl = 1'b0;
          else if (b == 9) lvl = 1'b1;
          else lvl = e[b-1];
          if (tx !== lvl) bad++;
          if (b >= 1 && b <= 8 && (c % l) == l / 2) got[b-1] = tx;
        end
        check("frame byte", {24'd0, got}, {24'd0, e});
        check("frame timing", bad, 0);
        frame_busy = 0;
      end
    end
  end

  logic [7:0] rd;
  logic       rs;
  logic       smp[64];

  function automatic logic exp_lvl(input int i);
    int b;
    logic [7:0] v;
    v = 8'h55;
    if (i < 16) b = i / 4;
    else b = 4 + (i - 16) / 8;
    if (b == 0) return 1'b0;
    if (b >= 9) return 1'b1;
    return v[b-1];
  endfunction

  initial begin
    int k, bad;
    reset   = 1'b1;
    address = IDLE_A;
    o_data  = 8'h00;
    we      = 1'b0;
    repeat (3) @(negedge clock);
    check("reset tx", tx, 1'b1);
    check("reset sel", sel, 1'b0);
    check("reset i_data", i_data, 8'h00);
    reset = 1'b0;

    bus_read(BASE + 16'd1, rd, rs);
    check("status after reset", rd, 8'h04);
    check("sel in window", rs, 1'b1);
    bus_read(IDLE_A, rd, rs);
    check("sel outside", rs, 1'b0);
    check("data outside", rd, 8'h00);
    bus_read(BASE, rd, rs);
    check("data reg read", rd, 8'h00);
    bus_read(BASE + 16'd2, rd, rs);
    check("baud lo reset", rd, 8'hD8);
    bus_read(BASE + 16'd3, rd, rs);
    check("baud hi reset", rd, 8'h00);

    bus_write(BASE + 16'd2, 8'd3);
    bus_write(BASE + 16'd3, 8'd0);
    bus_read(BASE + 16'd2, rd, rs);
    check("baud lo", rd, 8'h03);
    mon_div = 3;
    mon_en = 1;
    send(8'hA5);
    bus_read(BASE + 16'd1, rd, rs);
    check("busy during frame", rd[0], 1'b1);
    wait_drain(200);
    @(negedge clock);
    bus_read(BASE + 16'd1, rd, rs);
    check("idle after frame", rd, 8'h04);

    for (int i = 1; i <= 5; i++) send(8'(i));
    wait_drain(600);
    @(negedge clock);
    bus_read(BASE + 16'd1, rd, rs);
    check("five writes no ovf", rd, 8'h04);

    for (int i = 0; i < 6; i++) begin
      if (i < 5) send(8'h10 + 8'(i));
      else bus_write(BASE, 8'hEE);
    end
    bus_read(BASE + 16'd1, rd, rs);
    check("ovf status", rd, 8'h0B);
    bus_read(BASE + 16'd1, rd, rs);
    check("ovf cleared", rd, 8'h03);
    wait_drain(600);
    @(negedge clock);

    // Divisor change inside data bit 2.
    mon_en = 0;
    bus_write(BASE, 8'h55);
    k = 0;
    while (tx !== 1'b0 && k < 20) begin
      @(negedge clock);
      k++;
    end
    check("div test start", 32'(k < 20), 32'd1);
    fork
      begin
        smp[0] = tx;
        for (int i = 1; i < 64; i++) begin
          @(negedge clock);
          smp[i] = tx;
        end
      end
      begin
        repeat (11) @(negedge clock);
        bus_write(BASE + 16'd2, 8'd7);
      end
    join
    bad = 0;
    for (int i = 0; i < 64; i++) if (smp[i] !== exp_lvl(i)) bad++;
    check("div change wave", bad, 0);
    @(negedge clock);
    check("div change idle", tx, 1'b1);
    bus_write(BASE + 16'd2, 8'd3);
    repeat (4) @(negedge clock);

    // Reset mid-frame with bytes still queued.
    bus_write(BASE, 8'h00);
    bus_write(BASE, 8'h11);
    bus_write(BASE, 8'h22);
    bus_write(BASE, 8'h33);
    k = 0;
    while (tx !== 1'b0 && k < 20) begin
      @(negedge clock);
      k++;
    end
    repeat (8) @(negedge clock);
    check("tx low pre reset", tx, 1'b0);
    #2 reset = 1'b1;
    #1 check("tx async reset", tx, 1'b1);
    @(negedge clock);
    reset = 1'b0;
    bus_read(BASE + 16'd1, rd, rs);
    check("status post reset", rd, 8'h04);
    bus_read(BASE + 16'd2, rd, rs);
    check("baud post reset", rd, 8'hD8);
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (tx !== 1'b1) bad++;
    end
    check("no frames after reset", bad, 0);

`ifdef UART_TX_IRQ_EN
    bus_write(BASE + 16'd2, 8'd3);
    bus_write(BASE + 16'd1, 8'h10);
    bus_read(BASE + 16'd1, rd, rs);
    check("ie readback", rd, 8'h14);
    mon_en = 1;
    send(8'h3C);
    check("irq low busy", irq, 1'b0);
    wait_drain(200);
    repeat (3) @(negedge clock);
    check("irq high", irq, 1'b1);
    send(8'h00);
    @(negedge clock);
    check("irq drop", irq, 1'b0);
    wait_drain(200);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
